// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: pixel-code stream from the game core (pix_valid qualifies pix_code each edge)
interface led_matrix_scanner_if;
  logic       pix_valid;
  logic [9:0] pix_code;
  modport master (output pix_valid, pix_code);
  modport slave  (input pix_valid, pix_code);
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: decodes pixel codes into a back buffer, swaps to front each frame, scans rows (CLK/RST sync high, pix stream in, row_addr/row_en/col_data/frame_tick out)
module led_matrix_scanner #(
  parameter int FRAME_CYCLES = 256256,
  parameter int ROW_CYCLES   = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  led_matrix_scanner_if.slave  pix,
  output logic [4:0]           row_addr,
  output logic                 row_en,
  output logic [15:0]          col_data,
  output logic                 frame_tick
);
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int DW = $clog2((ROW_CYCLES > BLANK_CYCLES ? ROW_CYCLES : BLANK_CYCLES) + 1);
  typedef enum logic {BLANK, ROW_ON} state_t;
  state_t        state, state_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [FW-1:0] frame_cnt;
  logic [15:0]   back [32];
  logic [15:0]   front [32];
  logic [15:0]   wmask;
  logic [3:0]    wx;
  logic [4:0]    wy;
  logic          swap, swap_q, leave;
  always_comb begin
    wx    = pix.pix_code[8] ? pix.pix_code[7:4] : 4'd15 - pix.pix_code[7:4];
    wy    = pix.pix_code[8] ? 5'd31 - {1'b0, pix.pix_code[3:0]} : {1'b0, pix.pix_code[3:0]};
    wmask = (pix.pix_valid && !pix.pix_code[9]) ? 16'd1 << wx : 16'd0;
    swap  = frame_cnt == FW'(FRAME_CYCLES - 1);
  end
  // the swap edge folds that edge's own pixel straight into front
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt  <= '0;
      swap_q     <= 1'b0;
      frame_tick <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      frame_cnt  <= swap ? '0 : frame_cnt + 1'b1;
      swap_q     <= swap;
      frame_tick <= swap_q;
      for (int i = 0; i < 32; i++) begin
        if (swap) begin
          front[i] <= back[i] | (wy == 5'(i) ? wmask : 16'd0);
          back[i]  <= '0;
        end else if (wy == 5'(i)) begin
          back[i] <= back[i] | wmask;
        end
      end
    end
  end
  // dwell counts from 1 on state entry; reset leaves it at 0 so the first blank is one edge longer
  always_comb begin
    leave     = dwell == (state == ROW_ON ? DW'(ROW_CYCLES) : DW'(BLANK_CYCLES));
    state_nxt = leave ? (state == BLANK ? ROW_ON : BLANK) : state;
    dwell_nxt = leave ? DW'(1) : dwell + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= BLANK;
      dwell    <= '0;
      row_addr <= '0;
      row_en   <= 1'b0;
      col_data <= '0;
    end else begin
      state    <= state_nxt;
      dwell    <= dwell_nxt;
      row_en   <= state_nxt == ROW_ON;
      col_data <= state_nxt == BLANK ? 16'd0 : (state == BLANK ? front[row_addr] : col_data);
      row_addr <= (state == ROW_ON && state_nxt == BLANK) ? row_addr + 1'b1 : row_addr;
    end
  end
endmodule
